// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a per-grant hold limit.
// Ports: clk, rst (async, active high), en, req[7:0] in;
//        gnt[7:0], gnt_idx[2:0], gnt_valid, preempt out (all registered).
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [2:0]    ptr_q;
    logic [2:0]    ptr_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    gnt_d;
    logic [2:0]    idx_d;
    logic          valid_d;
    logic          pre_d;

    logic [2:0]    cand;
    logic [2:0]    pick_idx;
    logic          pick_hit;
    logic          own_req;
    logic          hold_done;

    // Rotating priority search. Offsets are scanned from 7 down to 0
    // so the last hit, i.e. the one closest to ptr, wins.
    always_comb begin
        cand     = ptr_q;
        pick_idx = ptr_q;
        pick_hit = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr_q + 3'(i);
            if (req[cand]) begin
                pick_hit = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign own_req   = req[gnt_idx];
    assign hold_done = (cnt_q == HOLD_MAX);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        valid_d = gnt_valid;
        pre_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && pick_hit) begin
                    state_d = BUSY;
                    gnt_d   = 8'h01 << pick_idx;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = HOLD_ONE;
                end
            end
            BUSY: begin
                // Release is tested first so it masks a
                // coincident timeout and suppresses preempt.
                if (!own_req) begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    valid_d = 1'b0;
                    ptr_d   = gnt_idx + 3'd1;
                    cnt_d   = '0;
                end else if (hold_done) begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    valid_d = 1'b0;
                    pre_d   = 1'b1;
                    ptr_d   = gnt_idx + 3'd1;
                    cnt_d   = '0;
                end else if (cnt_q < HOLD_MAX) begin
                    cnt_d   = cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            cnt_q     <= '0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= valid_d;
            preempt   <= pre_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scenario bench for rr_arbiter8 (MAX_HOLD=4).
// Expected outputs are queued per driven cycle and popped after the edge.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks;
    int errors;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } exp_t;

    exp_t sb[$];

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        req = 8'h00;
        en  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        req = 8'hFF;
        en  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            e = '{gnt: 8'h00, idx: 3'd0, valid: 1'b0, pre: 1'b0};
            sb.push_back(e);
            if (c == 0) #1;
            else begin
                @(posedge clk);
                #1;
            end
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx ||
                gnt_valid !== e.valid || preempt !== e.pre) begin
                errors++;
                $display("FAIL reset c%0d got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, gnt, gnt_idx, gnt_valid, preempt,
                         e.gnt, e.idx, e.valid, e.pre);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            req = (c == 0) ? 8'hFF : 8'h00;
            e.gnt   = (c == 0) ? 8'h01 : 8'h00;
            e.idx   = 3'd0;
            e.valid = (c == 0);
            e.pre   = 1'b0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx ||
                gnt_valid !== e.valid || preempt !== e.pre) begin
                errors++;
                $display("FAIL reset_first c%0d got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, gnt, gnt_idx, gnt_valid, preempt,
                         e.gnt, e.idx, e.valid, e.pre);
            end
        end
    endtask

    task automatic test_hold_release();
        logic [7:0] rq [8] = '{8'h24, 8'h24, 8'h24, 8'h20,
                               8'h20, 8'h00, 8'h81, 8'h00};
        logic [7:0] eg [8] = '{8'h04, 8'h04, 8'h04, 8'h00,
                               8'h20, 8'h00, 8'h80, 8'h00};
        logic [2:0] ei [8] = '{3'd2, 3'd2, 3'd2, 3'd2,
                               3'd5, 3'd5, 3'd7, 3'd7};
        exp_t e;
        apply_reset();
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req = rq[c];
            e = '{gnt: eg[c], idx: ei[c], valid: |eg[c], pre: 1'b0};
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx ||
                gnt_valid !== e.valid || preempt !== e.pre) begin
                errors++;
                $display("FAIL hold_release c%0d got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, gnt, gnt_idx, gnt_valid, preempt,
                         e.gnt, e.idx, e.valid, e.pre);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] rq [12] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
                                8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
        logic [7:0] eg [12] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80,
                                8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
        logic       ep [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_t e;
        apply_reset();
        en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req = rq[c];
            e = '{gnt: eg[c], idx: 3'd7, valid: |eg[c], pre: ep[c]};
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx ||
                gnt_valid !== e.valid || preempt !== e.pre) begin
                errors++;
                $display("FAIL timeout c%0d got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, gnt, gnt_idx, gnt_valid, preempt,
                         e.gnt, e.idx, e.valid, e.pre);
            end
        end
    endtask

    task automatic test_fairness();
        exp_t       e;
        logic [2:0] k;
        apply_reset();
        en = 1'b1;
        for (int c = 0; c < 18; c++) begin
            k = 3'(c / 2);
            if (c % 2 == 0) begin
                req   = 8'hFF;
                e.gnt = 8'h01 << k;
            end else begin
                req   = 8'hFF & ~(8'h01 << k);
                e.gnt = 8'h00;
            end
            e.idx   = k;
            e.valid = |e.gnt;
            e.pre   = 1'b0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx ||
                gnt_valid !== e.valid || preempt !== e.pre) begin
                errors++;
                $display("FAIL fairness c%0d got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, gnt, gnt_idx, gnt_valid, preempt,
                         e.gnt, e.idx, e.valid, e.pre);
            end
        end
    endtask

    task automatic test_enable();
        logic       ee [8] = '{1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] rq [8] = '{8'h08, 8'h08, 8'hFF, 8'h00,
                               8'hFF, 8'hFF, 8'hFF, 8'h00};
        logic [7:0] eg [8] = '{8'h08, 8'h08, 8'h08, 8'h00,
                               8'h00, 8'h00, 8'h10, 8'h00};
        logic [2:0] ei [8] = '{3'd3, 3'd3, 3'd3, 3'd3,
                               3'd3, 3'd3, 3'd4, 3'd4};
        exp_t e;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            en  = ee[c];
            req = rq[c];
            e = '{gnt: eg[c], idx: ei[c], valid: |eg[c], pre: 1'b0};
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx ||
                gnt_valid !== e.valid || preempt !== e.pre) begin
                errors++;
                $display("FAIL enable c%0d got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, gnt, gnt_idx, gnt_valid, preempt,
                         e.gnt, e.idx, e.valid, e.pre);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] rq [5] = '{8'h02, 8'h00, 8'h10, 8'h11, 8'h00};
        logic [7:0] eg [5] = '{8'h02, 8'h00, 8'h10, 8'h01, 8'h00};
        logic [2:0] ei [5] = '{3'd1, 3'd1, 3'd4, 3'd0, 3'd0};
        exp_t e;
        apply_reset();
        en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                rst = 1'b1;
                e = '{gnt: 8'h00, idx: 3'd0, valid: 1'b0, pre: 1'b0};
                sb.push_back(e);
                #2;
            end else begin
                req = rq[(c > 3) ? c - 1 : c];
                e.gnt   = eg[(c > 3) ? c - 1 : c];
                e.idx   = ei[(c > 3) ? c - 1 : c];
                e.valid = |e.gnt;
                e.pre   = 1'b0;
                sb.push_back(e);
                @(posedge clk);
                #1;
            end
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_idx !== e.idx ||
                gnt_valid !== e.valid || preempt !== e.pre) begin
                errors++;
                $display("FAIL async_reset c%0d got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, gnt, gnt_idx, gnt_valid, preempt,
                         e.gnt, e.idx, e.valid, e.pre);
            end
            if (c == 3) begin
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b0;
        req    = 8'h00;
        test_reset();
        test_hold_release();
        test_timeout();
        test_fairness();
        test_enable();
        test_async_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
